// File: rtl/md_ctrl_pkg.sv
// Shared op codes, FSM states and op classification for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU accumulate ops).
package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MUL  = 3'd1,
    CLS_DIV  = 3'd2,
    CLS_MTHI = 3'd3,
    CLS_MTLO = 3'd4
  } md_cls_e;

  // Accumulate codes fall through to CLS_NONE when the feature is not built in.
  function automatic md_cls_e md_op_class(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return CLS_MUL;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return CLS_MUL;
`endif
      MD_DIV, MD_DIVU:   return CLS_DIV;
      MD_MTHI:           return CLS_MTHI;
      MD_MTLO:           return CLS_MTLO;
      default:           return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/md_ctrl_calc.sv
// md_calc: combinational result generator producing the pending HI/LO values for an MDU op.
// Accumulate adder present only when MDU_MADD_EN is defined.
module md_calc
  import md_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo
);

  logic        mul_sgn;
  logic [63:0] prod;
  logic        div_sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
`ifdef MDU_MADD_EN
  logic        acc_sub;
  logic [63:0] acc;
`endif

  // One shared multiplier: signed ops sign-extend, unsigned ops zero-extend.
  always_comb begin
    mul_sgn = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    prod    = {{32{mul_sgn & a[31]}}, a} * {{32{mul_sgn & b[31]}}, b};
  end

  // Signed divide runs on magnitudes so the INT_MIN / -1 case stays well defined.
  always_comb begin
    div_sgn = (op == MD_DIV);
    a_mag   = (div_sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag   = (div_sgn && b[31]) ? (~b + 32'd1) : b;
    b_div   = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_div;
    r_mag   = a_mag % b_div;
    quo     = (div_sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem     = (div_sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;
  end

`ifdef MDU_MADD_EN
  always_comb begin
    acc_sub = (op == MD_MSUB) || (op == MD_MSUBU);
    acc     = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
  end
`endif

  always_comb begin
    pend_hi = hi;
    pend_lo = lo;
    case (op)
      MD_MULT, MD_MULTU: begin
        pend_hi = prod[63:32];
        pend_lo = prod[31:0];
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
        pend_hi = acc[63:32];
        pend_lo = acc[31:0];
      end
`endif
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          pend_hi = rem;
          pend_lo = quo;
        end
      end
      default: begin
        pend_hi = hi;
        pend_lo = lo;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer owning HI/LO, with busy flag and D-stage stall request.
// Optional feature macro: MDU_MADD_EN (accumulate ops, decoded in md_ctrl_pkg / md_calc).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; MTHI/MTLO write directly, mul/div latch and launch
// ST_RUN  | counting down latency; pending result lands when cnt == 1
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [31:0]      pend_hi, pend_lo;
  logic [31:0]      pend_hi_nxt, pend_lo_nxt;
  logic [31:0]      calc_hi, calc_lo;
  md_cls_e          cls;

  md_calc u_calc (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .pend_hi (calc_hi),
    .pend_lo (calc_lo)
  );

  assign cls = md_op_class(op);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  // A start seen in ST_RUN is dropped; the stall request keeps it from happening.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (cls)
            CLS_MUL: begin
              pend_hi_nxt = calc_hi;
              pend_lo_nxt = calc_lo;
              cnt_nxt     = MUL_CNT;
              state_nxt   = ST_RUN;
            end
            CLS_DIV: begin
              pend_hi_nxt = calc_hi;
              pend_lo_nxt = calc_lo;
              cnt_nxt     = DIV_CNT;
              state_nxt   = ST_RUN;
            end
            CLS_MTHI: hi_nxt = a;
            CLS_MTLO: lo_nxt = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy  = (state == ST_RUN);
  assign stall = md_D & (busy | start);

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus pushes expected HI/LO/latency from a reference model,
// a monitor process pops and checks as each operation completes.
`timescale 1ns/1ps
module tb_md_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .md_D  (md_D),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .stall (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          issued = 0;
  int          done   = 0;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Reference model: 64-bit arithmetic straight from the op definitions.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                             output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p, acc;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    acc = {m_hi, m_lo};
    lat = 0;
    case (o)
      OP_MULT:  begin p = sa * sb; acc = p; lat = MUL_LAT; end
      OP_MULTU: begin p = {32'd0, av} * {32'd0, bv}; acc = p; lat = MUL_LAT; end
      OP_DIV: begin
        lat = DIV_LAT;
        if (bv != 0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (bv != 0) acc = {av % bv, av / bv};
      end
      OP_MTHI: acc = {av, m_lo};
      OP_MTLO: acc = {m_hi, av};
`ifdef MDU_MADD_EN
      OP_MADD:  begin p = sa * sb; acc = acc + p; lat = MUL_LAT; end
      OP_MADDU: begin p = {32'd0, av} * {32'd0, bv}; acc = acc + p; lat = MUL_LAT; end
      OP_MSUB:  begin p = sa * sb; acc = acc - p; lat = MUL_LAT; end
      OP_MSUBU: begin p = {32'd0, av} * {32'd0, bv}; acc = acc - p; lat = MUL_LAT; end
`endif
      default: ;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
    eh   = acc[63:32];
    el   = acc[31:0];
  endtask

  // Monitor: item is queued just before its start edge; count busy cycles then check HI/LO.
  initial begin : monitor
    exp_t e;
    int   n;
    forever begin
      wait (issued != done);
      e = exp_q.pop_front();
      @(posedge clk); #1;
      n = 0;
      while (busy && n < e.lat + 4) begin
        n++;
        @(posedge clk); #1;
      end
      chk("busy_cycles", 64'(n), 64'(e.lat));
      chk("hi", {32'd0, hi}, {32'd0, e.hi});
      chk("lo", {32'd0, lo}, {32'd0, e.lo});
      done++;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic d, input bit st_chk);
    exp_t e;
    int   n;
    @(negedge clk);
    model_apply(o, av, bv, e.hi, e.lo, e.lat);
    op = o; a = av; b = bv; md_D = d; start = 1'b1;
    exp_q.push_back(e);
    issued++;
    if (st_chk) begin
      #1;
      chk("stall_start", {63'd0, stall}, {63'd0, d});
    end
    @(negedge clk);
    start = 1'b0;
    if (st_chk) begin
      for (int k = 0; k < e.lat; k++) begin
        chk("stall_busy", {63'd0, stall}, {63'd0, d});
        @(negedge clk);
      end
      chk("stall_after", {63'd0, stall}, 64'd0);
    end
    n = 0;
    while (done != issued && n < 64) begin
      @(negedge clk);
      n++;
    end
    md_D = 1'b0;
    if (done != issued) begin
      total++;
      $display("FAIL issue_timeout: op %0d still pending after %0d cycles", o, n);
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "monitor stalled");
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'(longint'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk)
    if (rst) assert (!(start && busy)) else $error("FAIL start_while_busy: start issued with busy high");

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    rst = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0; md_D = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;

    issue(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(OP_MTHI,  32'h0000_0011, 32'd0, 1'b0, 1'b0);
    issue(OP_MTLO,  32'h0000_0022, 32'd0, 1'b0, 1'b0);
    issue(OP_DIVU,  32'd7,         32'd0, 1'b0, 1'b0);
    issue(OP_MTHI,  32'h1234_5678, 32'd0, 1'b0, 1'b0);
    issue(OP_MTLO,  32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
    issue(OP_MULT,  32'd3, 32'hFFFF_FFFB, 1'b1, 1'b1);
    issue(OP_MULT,  32'd7, 32'd9,         1'b0, 1'b1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(OP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Asynchronous reset two cycles into a divide: everything clears at once.
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hi", {32'd0, hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (DIV_LAT + 2) @(negedge clk);
    chk("rst_no_late_result", {hi, lo}, 64'd0);
    issue(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0);

    issue(OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
    issue(OP_MADD, 32'h8000_0000, 32'd2, 1'b0, 1'b0);
    issue(OP_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = pick_operand();
      rb = pick_operand();
      issue(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the five-stage MIPS pipeline. Sits beside the ALU in the E stage and owns the HI/LO registers. Accepts one mult/div/move-to operation per start pulse and sequences it over a fixed multi-cycle latency. Drives a busy flag and a D-stage stall request that the stall unit ORs into its existing hazard stall.

## Interface
- MUL_LAT, 5, cycles busy after a multiply start (≥1)
- DIV_LAT, 10, cycles busy after a divide start (≥1)
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is an MDU op; qualifies op/a/b this cycle
- op  in  4  operation code from the shared define file
- a  in  32  forwarded rs value (E stage)
- b  in  32  forwarded rt value (E stage)
- md_D  in  1  D-stage instruction uses the MDU (mult/div/mthi/mtlo/mfhi/mflo/madd/msub)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  multi-cycle operation in flight
- stall  out  1  stall request to the stall unit

## Operation
- States: IDLE, RUN. Counter cnt, width ceil(log2(max(MUL_LAT,DIV_LAT)))+1.
- IDLE, start with MULT/MULTU/MADD/MADDU/MSUB/MSUBU: latch computed result into pend_hi/pend_lo, cnt<=MUL_LAT, go RUN.
- IDLE, start with DIV/DIVU: latch quotient→pend_lo, remainder→pend_hi, cnt<=DIV_LAT, go RUN.
- IDLE, start with MTHI/MTLO: write a into hi/lo at that edge; stay IDLE; busy never rises.
- RUN: cnt decrements each edge; on edge where cnt==1, hi<=pend_hi, lo<=pend_lo, go IDLE.
- Multiply: signed (MULT) or unsigned (MULTU) 32×32→64, HI=[63:32], LO=[31:0].
- MADD/MADDU/MSUB/MSUBU: {hi,lo} ± product, modulo 2^64; {hi,lo} sampled at start.
- Divide: signed truncates toward zero, remainder takes sign of dividend; unsigned plain.
- Divide by zero: full DIV_LAT busy period, pend_hi/pend_lo = current hi/lo (registers unchanged).
- start while RUN: ignored (stall guarantees it never occurs; bench asserts).
- op MD_NONE or undefined with start: no effect.
- stall = md_D & (busy | start), combinational.

## Timing
- Reset (rst low, any time incl. mid-RUN): hi=0, lo=0, busy=0, state IDLE, cnt=0, pending discarded.
- start sampled at edge t0: busy=1 from t0 through t0+LAT; hi/lo show result and busy=0 after edge t0+LAT.
- MTHI/MTLO visible one edge after start.
- hi/lo are registered outputs; mfhi/mflo in E read them directly, no forwarding inside the block.
- stall asserted in the start cycle itself so a following MDU instruction in D holds.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU decoded as above.
- Not defined: these four codes treated as MD_NONE; accumulate adder removed.

## Structure
- Shared define file (md_def.v): op codes MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; state encodings.
- Sub-module md_calc: combinational a/b/op/hi/lo → pend_hi/pend_lo including div-by-zero hold.
- md_ctrl holds FSM, counter, HI/LO, stall logic.

## Test plan
- MULT a=0xFFFFFFFF b=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 b=2 -> after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=0 with hi=0x11,lo=0x22 -> busy 10 cycles, hi/lo unchanged.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> hi/lo updated one edge each, busy stays 0.
- MULT start with md_D=1 -> stall high in start cycle and 5 busy cycles, low afterwards; md_D=0 -> stall never high.
- rst pulled low 2 cycles into a DIV -> busy=0, hi=lo=0 immediately; after release next MULT runs normally.
- MDU_MADD_EN: hi=0 lo=0xFFFFFFFF, MADDU a=1 b=1 -> hi=1 lo=0; without macro same stimulus -> hi/lo unchanged, busy 0.
